// File: rtl/lane_pack_pkg.sv
// -----------------------------------------------------------------------------
// lane_pack_pkg
// Shared definitions for the lane_packer block.
//   LP_IN_W / LP_RATIO : default beat width and beats per packed word
//   CNT_W              : lane counter width for the default ratio
//   acc_state_e        : accumulator FSM states (EMPTY / FILLING)
//   keep_mask(cnt)     : ones in bits 0..cnt (lane-valid mask of a closing word)
// -----------------------------------------------------------------------------
package lane_pack_pkg;

  localparam int LP_IN_W  = 32;
  localparam int LP_RATIO = 4;
  localparam int LP_OUT_W = LP_IN_W * LP_RATIO;
  localparam int CNT_W    = $clog2(LP_RATIO);

  typedef enum logic {
    ST_EMPTY   = 1'b0,
    ST_FILLING = 1'b1
  } acc_state_e;

  // Generic up to 32 lanes; callers size-cast down to their RATIO.
  function automatic logic [31:0] keep_mask(input int cnt);
    logic [31:0] m;
    for (int i = 0; i < 32; i++) begin
      m[i] = (i <= cnt);
    end
    return m;
  endfunction

endpackage

// File: rtl/lane_packer_if.sv
// -----------------------------------------------------------------------------
// lane_packer_if
// Input beat stream and packed output word stream of lane_packer.
//   in_valid/in_ready/in_data/in_last      : narrow beat handshake
//   out_valid/out_ready/out_data/out_last  : packed word handshake
//   out_keep                               : lane-valid mask (LANE_PACK_KEEP_EN)
// Modports: slave = the packer, master = producer/consumer environment.
// -----------------------------------------------------------------------------
interface lane_packer_if #(
  parameter int IN_W  = 32,
  parameter int RATIO = 4
);
  logic                    in_valid;
  logic                    in_ready;
  logic [IN_W-1:0]         in_data;
  logic                    in_last;
  logic                    out_valid;
  logic                    out_ready;
  logic [IN_W*RATIO-1:0]   out_data;
  logic                    out_last;
`ifdef LANE_PACK_KEEP_EN
  logic [RATIO-1:0]        out_keep;
`endif

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last
`ifdef LANE_PACK_KEEP_EN
    , output out_keep
`endif
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last
`ifdef LANE_PACK_KEEP_EN
    , input out_keep
`endif
  );
endinterface

// File: rtl/lane_accum.sv
// -----------------------------------------------------------------------------
// lane_accum
// Lane accumulator: inserts accepted beats into acc at lane cnt and reports the
// fully formed (zero-padded) word when a beat completes it.
//   clk, rst_n  : clock, async active-low reset
//   i_accept    : beat accepted this cycle
//   i_data      : beat payload
//   i_last      : beat closes the current word
//   o_complete  : accepted beat completes the word this cycle
//   o_word      : acc with the current beat inserted, lanes above cnt zero
//   o_cnt       : lane index the current beat lands in
// -----------------------------------------------------------------------------
module lane_accum
  import lane_pack_pkg::*;
#(
  parameter int IN_W  = LP_IN_W,
  parameter int RATIO = LP_RATIO
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_accept,
  input  logic [IN_W-1:0]           i_data,
  input  logic                      i_last,
  output logic                      o_complete,
  output logic [IN_W*RATIO-1:0]     o_word,
  output logic [$clog2(RATIO)-1:0]  o_cnt
);

  localparam int OUT_W = IN_W * RATIO;
  localparam int CW    = $clog2(RATIO);

  acc_state_e       r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt,   w_cnt_nxt;
  logic [OUT_W-1:0] r_acc,   w_acc_nxt;
  logic [OUT_W-1:0] w_base;
  logic [OUT_W-1:0] w_word;
  logic             w_last_lane;

  // An EMPTY accumulator contributes nothing, so no stale lane can leak.
  always_comb begin
    w_base = '0;
    case (r_state)
      ST_FILLING: w_base = r_acc;
      default:    w_base = '0;
    endcase
    w_word = w_base;
    w_word[r_cnt*IN_W +: IN_W] = i_data;
  end

  assign w_last_lane = (r_cnt == CW'(RATIO - 1));
  assign o_complete  = i_accept & (w_last_lane | i_last);
  assign o_word      = w_word;
  assign o_cnt       = r_cnt;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_acc_nxt   = r_acc;
    if (i_accept) begin
      if (o_complete) begin
        w_state_nxt = ST_EMPTY;
        w_cnt_nxt   = '0;
        w_acc_nxt   = '0;
      end else begin
        w_state_nxt = ST_FILLING;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_acc_nxt   = w_word;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
      r_cnt   <= '0;
      r_acc   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_acc   <= w_acc_nxt;
    end
  end

endmodule

// File: rtl/lane_packer.sv
// -----------------------------------------------------------------------------
// lane_packer
// Packs IN_W-bit beats into OUT_W = IN_W*RATIO words (lane 0 in LSBs) and
// presents them on a registered valid/ready output. in_last closes a word
// early with zero-padded upper lanes.
//   clk, rst_n : clock, async active-low reset
//   bus        : lane_packer_if.slave (beat input, packed word output)
// Optional feature macro: LANE_PACK_KEEP_EN adds out_keep (lane-valid mask).
// -----------------------------------------------------------------------------
module lane_packer
  import lane_pack_pkg::*;
#(
  parameter int IN_W  = LP_IN_W,
  parameter int RATIO = LP_RATIO
) (
  input  logic          clk,
  input  logic          rst_n,
  lane_packer_if.slave  bus
);

  localparam int OUT_W = IN_W * RATIO;
  localparam int CW    = $clog2(RATIO);

  logic             w_in_ready;
  logic             w_accept;
  logic             w_complete;
  logic [OUT_W-1:0] w_word;
  logic [CW-1:0]    w_cnt;

  logic             r_out_v;
  logic [OUT_W-1:0] r_out_q;
  logic             r_out_last_q;

  // Input may flow whenever the output slot is free or being drained now.
  assign w_in_ready = ~r_out_v | bus.out_ready;
  assign w_accept   = bus.in_valid & w_in_ready;

  lane_accum #(
    .IN_W  (IN_W),
    .RATIO (RATIO)
  ) u_accum (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_accept   (w_accept),
    .i_data     (bus.in_data),
    .i_last     (bus.in_last),
    .o_complete (w_complete),
    .o_word     (w_word),
    .o_cnt      (w_cnt)
  );

  // A completing beat overrides a same-cycle drain so the slot stays full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_v      <= 1'b0;
      r_out_q      <= '0;
      r_out_last_q <= 1'b0;
    end else if (w_complete) begin
      r_out_v      <= 1'b1;
      r_out_q      <= w_word;
      r_out_last_q <= bus.in_last;
    end else if (bus.out_ready) begin
      r_out_v      <= 1'b0;
    end
  end

`ifdef LANE_PACK_KEEP_EN
  logic [RATIO-1:0] r_out_keep_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_keep_q <= '0;
    end else if (w_complete) begin
      r_out_keep_q <= RATIO'(keep_mask(int'(w_cnt)));
    end
  end

  assign bus.out_keep = r_out_keep_q;
`else
  // Lane index only feeds the keep mask; unused without it.
  logic w_cnt_unused;
  assign w_cnt_unused = ^w_cnt;
`endif

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_v;
  assign bus.out_data  = r_out_q;
  assign bus.out_last  = r_out_last_q;

endmodule

// File: tb/tb_lane_packer.sv
module tb_lane_packer;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  lane_packer_if #(.IN_W(32), .RATIO(4)) bus ();

  lane_packer #(.IN_W(32), .RATIO(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         v;
    logic [31:0]  d;
    logic         l;
    logic         ordy;
    logic         ir;
    logic         ov;
    logic [127:0] od;
    logic         ol;
    logic [3:0]   k;
  } vec_t;

  vec_t tbl [17];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic l, input logic ordy);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_last   = l;
    bus.out_ready = ordy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_keep(input string name, input logic [3:0] exp);
`ifdef LANE_PACK_KEEP_EN
    chk(name, 128'(bus.out_keep), 128'(exp));
`else
    if (exp === 4'hx) $display("unreachable %s", name);
`endif
  endtask

  function automatic logic [127:0] w4(input logic [31:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b1);

    //             v  data          last ordy ir  ov  out_data                                         ol  keep
    tbl[0]  = '{1, 32'h11,       0, 1,  1,  0,  128'h0,                                           0,  4'h0};
    tbl[1]  = '{1, 32'h22,       0, 1,  1,  0,  128'h0,                                           0,  4'h0};
    tbl[2]  = '{1, 32'h33,       0, 1,  1,  0,  128'h0,                                           0,  4'h0};
    tbl[3]  = '{1, 32'h44,       0, 1,  1,  1,  w4(32'h11, 32'h22, 32'h33, 32'h44),               0,  4'hF};
    tbl[4]  = '{1, 32'hA,        0, 1,  1,  0,  128'h0,                                           0,  4'h0};
    tbl[5]  = '{1, 32'hB,        1, 1,  1,  1,  w4(32'hA, 32'hB, 32'h0, 32'h0),                   1,  4'h3};
    tbl[6]  = '{1, 32'h5,        1, 1,  1,  1,  128'h5,                                           1,  4'h1};
    tbl[7]  = '{1, 32'h66,       0, 1,  1,  0,  128'h0,                                           0,  4'h0};
    tbl[8]  = '{0, 32'hDEAD,     0, 1,  1,  0,  128'h0,                                           0,  4'h0};
    tbl[9]  = '{1, 32'h77,       0, 1,  1,  0,  128'h0,                                           0,  4'h0};
    tbl[10] = '{1, 32'h88,       0, 1,  1,  0,  128'h0,                                           0,  4'h0};
    tbl[11] = '{1, 32'h99,       0, 1,  1,  1,  w4(32'h66, 32'h77, 32'h88, 32'h99),               0,  4'hF};
    tbl[12] = '{1, 32'hC1,       0, 1,  1,  0,  128'h0,                                           0,  4'h0};
    tbl[13] = '{1, 32'hC2,       0, 1,  1,  0,  128'h0,                                           0,  4'h0};
    tbl[14] = '{1, 32'hC3,       0, 1,  1,  0,  128'h0,                                           0,  4'h0};
    tbl[15] = '{1, 32'hC4,       1, 1,  1,  1,  w4(32'hC1, 32'hC2, 32'hC3, 32'hC4),               1,  4'hF};
    tbl[16] = '{0, 32'h0,        0, 1,  1,  0,  128'h0,                                           0,  4'h0};

    // Reset state
    tick();
    chk("rst_in_ready",  128'(bus.in_ready),  128'd1);
    chk("rst_out_valid", 128'(bus.out_valid), 128'd0);
    chk("rst_out_data",  bus.out_data,        128'd0);
    chk("rst_out_last",  128'(bus.out_last),  128'd0);
    chk_keep("rst_out_keep", 4'h0);
    rst_n = 1'b1;
    tick();

    // Table vectors
    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].ordy);
      #1;
      chk($sformatf("tbl%0d_in_ready", i), 128'(bus.in_ready), 128'(tbl[i].ir));
      tick();
      chk($sformatf("tbl%0d_out_valid", i), 128'(bus.out_valid), 128'(tbl[i].ov));
      if (tbl[i].ov) begin
        chk($sformatf("tbl%0d_out_data", i), bus.out_data, tbl[i].od);
        chk($sformatf("tbl%0d_out_last", i), 128'(bus.out_last), 128'(tbl[i].ol));
        chk_keep($sformatf("tbl%0d_out_keep", i), tbl[i].k);
      end
    end

    // 12 continuous beats, output drained every cycle
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 32'h300 + 32'(i), 1'b0, 1'b1);
      #1;
      chk($sformatf("stream%0d_in_ready", i), 128'(bus.in_ready), 128'd1);
      tick();
      chk($sformatf("stream%0d_out_valid", i), 128'(bus.out_valid), 128'((i % 4) == 3));
      if ((i % 4) == 3) begin
        chk($sformatf("stream%0d_out_data", i), bus.out_data,
            w4(32'h300 + 32'(i - 3), 32'h300 + 32'(i - 2), 32'h300 + 32'(i - 1), 32'h300 + 32'(i)));
      end
    end

    // Backpressure: stall after a word, then release
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h201 + 32'(i), 1'b0, 1'b1);
      tick();
    end
    chk("bp_first_word", bus.out_data, w4(32'h201, 32'h202, 32'h203, 32'h204));
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h100, 1'b0, 1'b0);
      #1;
      chk($sformatf("bp_stall%0d_in_ready", i), 128'(bus.in_ready), 128'd0);
      tick();
      chk($sformatf("bp_stall%0d_out_valid", i), 128'(bus.out_valid), 128'd1);
      chk($sformatf("bp_stall%0d_out_data", i), bus.out_data, w4(32'h201, 32'h202, 32'h203, 32'h204));
    end
    drive(1'b1, 32'h100, 1'b0, 1'b1);
    #1;
    chk("bp_release_in_ready", 128'(bus.in_ready), 128'd1);
    tick();
    chk("bp_release_out_valid", 128'(bus.out_valid), 128'd0);
    for (int i = 1; i < 4; i++) begin
      drive(1'b1, 32'h100 + 32'(i), 1'b0, 1'b1);
      tick();
    end
    chk("bp_resume_out_valid", 128'(bus.out_valid), 128'd1);
    chk("bp_resume_out_data", bus.out_data, w4(32'h100, 32'h101, 32'h102, 32'h103));

    // Reset mid-word
    drive(1'b1, 32'hE1, 1'b0, 1'b1);
    tick();
    drive(1'b1, 32'hE2, 1'b0, 1'b1);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready",  128'(bus.in_ready),  128'd1);
    chk("midrst_out_valid", 128'(bus.out_valid), 128'd0);
    chk("midrst_out_data",  bus.out_data,        128'd0);
    chk("midrst_out_last",  128'(bus.out_last),  128'd0);
    chk_keep("midrst_out_keep", 4'h0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'hF1 + 32'(i), 1'b0, 1'b1);
      tick();
      chk($sformatf("postrst%0d_out_valid", i), 128'(bus.out_valid), 128'(i == 3));
    end
    chk("postrst_out_data", bus.out_data, w4(32'hF1, 32'hF2, 32'hF3, 32'hF4));
    chk("postrst_out_last", 128'(bus.out_last), 128'd0);
    chk_keep("postrst_out_keep", 4'hF);
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
